lut_bank_pipe: RTL and testbench

//  Parametrised, registered successor to the fixed 4-in/13-out ABC benchmark logic blocks.

---
 rtl/lut_bank_pipe.sv | 91 +++++++++
 tb/tb_lut_bank_pipe.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/lut_bank_pipe.sv
// lut_bank_pipe: N_OUT run-time-loadable truth tables over N_IN inputs, evaluated
// on a valid/ready stream through a single registered output stage.
// Optional feature: define EVAL_CNT_EN to add a saturating 16-bit eval_cnt port
// that counts accepted inputs since reset.
module lut_bank_pipe #(
  parameter int unsigned N_IN  = 4,
  parameter int unsigned N_OUT = 13,
  parameter int unsigned AW    = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cfg_valid,
  output logic                    cfg_ready,
  input  logic [AW-1:0]           cfg_addr,
  input  logic [(2**N_IN)-1:0]    cfg_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N_IN-1:0]         x,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N_OUT-1:0]        f,
  output logic [N_OUT-1:0]        loaded
`ifdef EVAL_CNT_EN
  ,
  output logic [15:0]             eval_cnt
`endif
);

  localparam int unsigned TD = 2**N_IN;

  logic [TD-1:0]    tables [N_OUT];
  logic             cfg_fire;
  logic             in_fire;
  logic [N_OUT-1:0] f_next;

  // Tables may change only while the output stage is empty; config beats input.
  assign cfg_ready = ~out_valid;
  assign cfg_fire  = cfg_valid & cfg_ready;
  assign in_ready  = (~out_valid | out_ready) & ~cfg_fire;
  assign in_fire   = in_valid & in_ready;

  // Look up every table at the presented input vector.
  always_comb begin
    f_next = '0;
    for (int i = 0; i < int'(N_OUT); i++) begin
      f_next[i] = tables[i][x];
    end
  end

  // Table storage and per-table loaded flags; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(N_OUT); i++) begin
        tables[i] <= '0;
      end
      loaded <= '0;
    end else if (cfg_fire) begin
      for (int i = 0; i < int'(N_OUT); i++) begin
        if (cfg_addr == AW'(i)) begin
          tables[i] <= cfg_data;
          loaded[i] <= 1'b1;
        end
      end
    end
  end

  // Output stage: full/empty flag plus held result, stable while stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= '0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      f         <= f_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef EVAL_CNT_EN
  // Saturating count of accepted inputs; unaffected by config writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      eval_cnt <= '0;
    end else if (in_fire && (eval_cnt != 16'hFFFF)) begin
      eval_cnt <= eval_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_lut_bank_pipe.sv
// Directed, table-driven bench for lut_bank_pipe (N_IN=4, N_OUT=13, AW=4).
module tb_lut_bank_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  x;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] f;
  logic [12:0] loaded;
`ifdef EVAL_CNT_EN
  logic [15:0] eval_cnt;
`endif

  int checks = 0;
  int errors = 0;

  lut_bank_pipe #(.N_IN(4), .N_OUT(13), .AW(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_addr  (cfg_addr),
    .cfg_data  (cfg_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .f         (f),
    .loaded    (loaded)
`ifdef EVAL_CNT_EN
    ,
    .eval_cnt  (eval_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Inputs applied this cycle; expectations on registered outputs describe the
  // state before the next edge, readies are the combinational response.
  typedef struct {
    logic        cv;
    logic [3:0]  ca;
    logic [15:0] cd;
    logic        iv;
    logic [3:0]  xx;
    logic        ordy;
    logic        e_ir;
    logic        e_cr;
    logic        e_ov;
    logic [12:0] e_f;
    logic [12:0] e_ld;
  } vec_t;

  vec_t vt [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic cv, input logic [3:0] ca, input logic [15:0] cd,
                       input logic iv, input logic [3:0] xx, input logic ordy);
    cfg_valid = cv;
    cfg_addr  = ca;
    cfg_data  = cd;
    in_valid  = iv;
    x         = xx;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //            cv  ca    cd        iv  x     ordy ir   cr   ov   f         ld
    vt[0]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 13'h0000, 13'h0000};
    vt[1]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0000, 13'h0000};
    vt[2]  = '{1'b1, 4'd0,  16'h2222, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h0000, 13'h0000};
    vt[3]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 13'h0000, 13'h0001};
    vt[4]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'h3, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0001, 13'h0001};
    vt[5]  = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0000, 13'h0001};
    vt[6]  = '{1'b1, 4'd1,  16'hFFFF, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 13'h0000, 13'h0001};
    vt[7]  = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'h5, 1'b1, 1'b1, 1'b1, 1'b0, 13'h0000, 13'h0003};
    vt[8]  = '{1'b1, 4'd15, 16'hFFFF, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0003, 13'h0003};
    vt[9]  = '{1'b1, 4'd15, 16'hFFFF, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h0003, 13'h0003};
    vt[10] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 13'h0003, 13'h0003};
    vt[11] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0002, 13'h0003};
    vt[12] = '{1'b1, 4'd12, 16'h0001, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h0002, 13'h0003};
    vt[13] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 13'h0002, 13'h1003};
    vt[14] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h1002, 13'h1003};
    vt[15] = '{1'b1, 4'd0,  16'h0000, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 13'h1002, 13'h1003};
    vt[16] = '{1'b0, 4'd0,  16'h0000, 1'b1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 13'h1002, 13'h1003};
    vt[17] = '{1'b0, 4'd0,  16'h0000, 1'b0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b1, 13'h0002, 13'h1003};

    // Reset
    rst_n = 1'b0;
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'h0, 1'b0);
    repeat (3) tick();
    rst_n = 1'b1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_f", 32'(f), 32'd0);
    chk("rst_loaded", 32'(loaded), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef EVAL_CNT_EN
    chk("rst_eval_cnt", 32'(eval_cnt), 32'd0);
`endif

    // Table-driven vectors
    for (int i = 0; i < 18; i++) begin
      drive(vt[i].cv, vt[i].ca, vt[i].cd, vt[i].iv, vt[i].xx, vt[i].ordy);
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'(vt[i].e_ir));
      chk($sformatf("v%0d_cfg_ready", i), 32'(cfg_ready), 32'(vt[i].e_cr));
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'(vt[i].e_ov));
      chk($sformatf("v%0d_f", i), 32'(f), 32'(vt[i].e_f));
      chk($sformatf("v%0d_loaded", i), 32'(loaded), 32'(vt[i].e_ld));
      tick();
    end

    // Stall: output held for 5 cycles, config and input both blocked
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'h0, 1'b0);
    #1;
    chk("stall_accept_in_ready", 32'(in_ready), 32'd1);
    tick();
    for (int c = 0; c < 5; c++) begin
      drive(1'b1, 4'd2, 16'hFFFF, 1'b1, 4'h1, 1'b0);
      #1;
      chk($sformatf("stall%0d_out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d_f", c), 32'(f), 32'h1002);
      chk($sformatf("stall%0d_in_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("stall%0d_cfg_ready", c), 32'(cfg_ready), 32'd0);
      tick();
    end
    // Release: result consumed and next input accepted in the same cycle
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'h1, 1'b1);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'h0, 1'b0);
    #1;
    chk("release_out_valid", 32'(out_valid), 32'd1);
    chk("release_f", 32'(f), 32'h0002);
    chk("release_loaded", 32'(loaded), 32'h1003);

    // Reset while a result is held discards it and clears the tables
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_f", 32'(f), 32'd0);
    chk("midrst_loaded", 32'(loaded), 32'd0);
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'h5, 1'b1);
    tick();
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'h0, 1'b0);
    #1;
    chk("postrst_out_valid", 32'(out_valid), 32'd1);
    chk("postrst_f", 32'(f), 32'd0);
`ifdef EVAL_CNT_EN
    chk("postrst_eval_cnt", 32'(eval_cnt), 32'd1);
    // Saturation after more than 65535 back-to-back accepts
    drive(1'b0, 4'd0, 16'h0000, 1'b1, 4'h3, 1'b1);
    repeat (70000) tick();
    chk("sat_eval_cnt", 32'(eval_cnt), 32'hFFFF);
    drive(1'b0, 4'd0, 16'h0000, 1'b0, 4'h0, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("cnt_rst_eval_cnt", 32'(eval_cnt), 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
